// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - MIPS execute stage: operand forwarding, ALU, iterative multiplier
module ex_alu_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_aluOp,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rsData,
  input  logic [31:0] in_rtData,
  input  logic [31:0] in_imm,
  input  logic        in_useImm,
  input  logic [1:0]  in_memOp,
  input  logic        in_memWrite,
  input  logic        in_regWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic        exmem_regWrite,
  input  logic        memwb_regWrite,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic        out_valid,
  output logic [31:0] aluResult,
  output logic [31:0] address,
  output logic [31:0] dataIn,
  output logic [1:0]  memOp,
  output logic        writeEnable,
  output logic [4:0]  out_rd,
  output logic        out_regWrite
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [1:0] MEM_NONE = 2'b11;

  state_t      state;
  logic [4:0]  mul_cnt;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_acc;
  logic [31:0] mul_din;
  logic [31:0] mul_next;
  logic [4:0]  mul_rd;
  logic [1:0]  mul_memop;
  logic        mul_memwr;
  logic        mul_regwr;

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [31:0] op_b;
  logic [31:0] alu_res;

  assign in_ready = (state == IDLE);
  assign address  = aluResult;
  assign op_b     = in_useImm ? in_imm : fwd_rt;

  // Forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded
  always_comb begin
    fwd_rs = in_rsData;
    fwd_rt = in_rtData;
    if (exmem_regWrite && (exmem_rd != 5'd0) && (exmem_rd == in_rs))
      fwd_rs = exmem_result;
    else if (memwb_regWrite && (memwb_rd != 5'd0) && (memwb_rd == in_rs))
      fwd_rs = memwb_result;
    if (exmem_regWrite && (exmem_rd != 5'd0) && (exmem_rd == in_rt))
      fwd_rt = exmem_result;
    else if (memwb_regWrite && (memwb_rd != 5'd0) && (memwb_rd == in_rt))
      fwd_rt = memwb_result;
  end

  // Single-cycle ALU; MUL and unused opcodes yield 0 here
  always_comb begin
    alu_res = 32'd0;
    case (in_aluOp)
      OP_ADD:  alu_res = fwd_rs + op_b;
      OP_SUB:  alu_res = fwd_rs - op_b;
      OP_AND:  alu_res = fwd_rs & op_b;
      OP_OR:   alu_res = fwd_rs | op_b;
      OP_XOR:  alu_res = fwd_rs ^ op_b;
      OP_SLT:  alu_res = {31'd0, ($signed(fwd_rs) < $signed(op_b))};
      OP_SLL:  alu_res = fwd_rs << op_b[4:0];
      OP_SRL:  alu_res = fwd_rs >> op_b[4:0];
      OP_SRA:  alu_res = $unsigned($signed(fwd_rs) >>> op_b[4:0]);
      default: alu_res = 32'd0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign mul_next = mul_acc + (mul_b[0] ? mul_a : 32'd0);

  // Stage FSM: flush beats accept/completion; bubbles keep result, store data and rd
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mul_cnt      <= 5'd0;
      mul_a        <= 32'd0;
      mul_b        <= 32'd0;
      mul_acc      <= 32'd0;
      mul_din      <= 32'd0;
      mul_rd       <= 5'd0;
      mul_memop    <= MEM_NONE;
      mul_memwr    <= 1'b0;
      mul_regwr    <= 1'b0;
      out_valid    <= 1'b0;
      aluResult    <= 32'd0;
      dataIn       <= 32'd0;
      memOp        <= MEM_NONE;
      writeEnable  <= 1'b0;
      out_rd       <= 5'd0;
      out_regWrite <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      mul_cnt      <= 5'd0;
      out_valid    <= 1'b0;
      memOp        <= MEM_NONE;
      writeEnable  <= 1'b0;
      out_regWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && (in_aluOp == OP_MUL)) begin
            state        <= MUL;
            mul_cnt      <= 5'd0;
            mul_a        <= fwd_rs;
            mul_b        <= op_b;
            mul_acc      <= 32'd0;
            mul_din      <= fwd_rt;
            mul_rd       <= in_rd;
            mul_memop    <= in_memOp;
            mul_memwr    <= in_memWrite;
            mul_regwr    <= in_regWrite;
            out_valid    <= 1'b0;
            memOp        <= MEM_NONE;
            writeEnable  <= 1'b0;
            out_regWrite <= 1'b0;
          end else if (in_valid) begin
            out_valid    <= 1'b1;
            aluResult    <= alu_res;
            dataIn       <= fwd_rt;
            memOp        <= in_memOp;
            writeEnable  <= in_memWrite;
            out_rd       <= in_rd;
            out_regWrite <= in_regWrite;
          end else begin
            out_valid    <= 1'b0;
            memOp        <= MEM_NONE;
            writeEnable  <= 1'b0;
            out_regWrite <= 1'b0;
          end
        end
        MUL: begin
          if (mul_cnt == 5'd31) begin
            state        <= IDLE;
            mul_cnt      <= 5'd0;
            out_valid    <= 1'b1;
            aluResult    <= mul_next;
            dataIn       <= mul_din;
            memOp        <= mul_memop;
            writeEnable  <= mul_memwr;
            out_rd       <= mul_rd;
            out_regWrite <= mul_regwr;
          end else begin
            mul_cnt      <= mul_cnt + 5'd1;
            mul_acc      <= mul_next;
            mul_a        <= mul_a << 1;
            mul_b        <= mul_b >> 1;
            out_valid    <= 1'b0;
            memOp        <= MEM_NONE;
            writeEnable  <= 1'b0;
            out_regWrite <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - self-checking bench for ex_alu_stage
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [3:0]  in_aluOp;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rsData, in_rtData, in_imm;
  logic        in_useImm;
  logic [1:0]  in_memOp;
  logic        in_memWrite, in_regWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regWrite, memwb_regWrite;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid;
  logic [31:0] aluResult, address, dataIn;
  logic [1:0]  memOp;
  logic        writeEnable;
  logic [4:0]  out_rd;
  logic        out_regWrite;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_alu_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluOp(in_aluOp), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rsData(in_rsData), .in_rtData(in_rtData), .in_imm(in_imm), .in_useImm(in_useImm),
    .in_memOp(in_memOp), .in_memWrite(in_memWrite), .in_regWrite(in_regWrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regWrite(exmem_regWrite), .memwb_regWrite(memwb_regWrite),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .out_valid(out_valid), .aluResult(aluResult), .address(address), .dataIn(dataIn),
    .memOp(memOp), .writeEnable(writeEnable), .out_rd(out_rd), .out_regWrite(out_regWrite)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic        useimm;
    logic [1:0]  memop;
    logic        memwr, regwr;
    logic [4:0]  rd;
    logic [4:0]  exrd;
    logic        exwe;
    logic [31:0] exres;
    logic [4:0]  wbrd;
    logic        wbwe;
    logic [31:0] wbres;
    logic [31:0] exp_res, exp_din;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_aluOp = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_rsData = 0; in_rtData = 0; in_imm = 0; in_useImm = 0; in_memOp = 2'b11;
    in_memWrite = 0; in_regWrite = 0; exmem_rd = 0; memwb_rd = 0;
    exmem_regWrite = 0; memwb_regWrite = 0; exmem_result = 0; memwb_result = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " aluResult"}, aluResult, 32'd0);
    check({tag, " address"}, address, 32'd0);
    check({tag, " dataIn"}, dataIn, 32'd0);
    check({tag, " out_rd"}, {27'd0, out_rd}, 32'd0);
    check({tag, " memOp"}, {30'd0, memOp}, 32'd3);
    check({tag, " writeEnable"}, {31'd0, writeEnable}, 32'd0);
    check({tag, " out_regWrite"}, {31'd0, out_regWrite}, 32'd0);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Reference forwarding: newest producer wins, r0 is hardwired
  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
    if (src != 0 && exmem_regWrite && exmem_rd == src) return exmem_result;
    if (src != 0 && memwb_regWrite && memwb_rd == src) return memwb_result;
    return rf;
  endfunction

  // Reference ALU from the opcode table; MUL is the plain truncated product
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    longint sa;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd9: return 32'(longint'(a) * longint'(b));
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic hold_add, input string tag);
    int n_low;
    logic seen;
    logic [31:0] prod;
    prod = 32'(longint'(a) * longint'(b));
    clear_inputs();
    in_aluOp = 4'd9; in_rs = 5'd1; in_rt = 5'd2; in_rsData = a; in_rtData = b;
    in_rd = 5'd9; in_regWrite = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = hold_add;
    in_aluOp = 4'd0; in_rsData = 32'd7; in_rtData = 32'd8; in_rd = 5'd10;
    n_low = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin seen = 1; break; end
      if (!in_ready) n_low++;
      @(posedge clk); #1;
    end
    check({tag, " completed"}, {31'd0, seen}, 32'd1);
    check({tag, " ready low cycles"}, n_low, 32'd32);
    check({tag, " product"}, aluResult, prod);
    check({tag, " address"}, address, prod);
    check({tag, " dataIn"}, dataIn, b);
    check({tag, " out_rd"}, {27'd0, out_rd}, 32'd9);
    check({tag, " out_regWrite"}, {31'd0, out_regWrite}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    if (hold_add) begin
      check({tag, " held add valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " held add result"}, aluResult, 32'd15);
      check({tag, " held add rd"}, {27'd0, out_rd}, 32'd10);
    end else begin
      check({tag, " single pulse"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] m_res, m_din;
    logic [4:0]  m_rd;
    logic [1:0]  m_memop;
    logic        m_valid, m_we, m_rw;
    int          pulses;

    //              op    rs    rt    rsd           rtd     imm   ui  mop    mw  rw  rd     exrd  exwe  exres          wbrd  wbwe  wbres          exp_res        exp_din
    vecs[0] = '{4'd0, 5'd5, 5'd6, 32'd10,       32'd20, 32'd0, 0, 2'b00, 0, 1, 5'd7,  5'd0, 0, 32'd0,        5'd0, 0, 32'd0,        32'd30,        32'd20};
    vecs[1] = '{4'd0, 5'd5, 5'd6, 32'd10,       32'd20, 32'd1, 1, 2'b11, 0, 1, 5'd8,  5'd5, 1, 32'd100,      5'd5, 1, 32'd200,      32'd101,       32'd20};
    vecs[2] = '{4'd0, 5'd0, 5'd6, 32'd7,        32'd20, 32'd1, 1, 2'b11, 0, 1, 5'd8,  5'd0, 1, 32'd99,       5'd0, 1, 32'd77,       32'd8,         32'd20};
    vecs[3] = '{4'd8, 5'd1, 5'd2, 32'h80000000, 32'd0,  32'd4, 1, 2'b11, 0, 1, 5'd3,  5'd0, 0, 32'd0,        5'd0, 0, 32'd0,        32'hF8000000,  32'd0};
    vecs[4] = '{4'd5, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd1,  32'd0, 0, 2'b11, 0, 1, 5'd3,  5'd0, 0, 32'd0,        5'd0, 0, 32'd0,        32'd1,         32'd1};
    vecs[5] = '{4'd1, 5'd1, 5'd2, 32'd0,        32'd1,  32'd0, 0, 2'b11, 0, 1, 5'd3,  5'd0, 0, 32'd0,        5'd0, 0, 32'd0,        32'hFFFFFFFF,  32'd1};
    vecs[6] = '{4'd0, 5'd1, 5'd3, 32'h100,      32'd5,  32'd4, 1, 2'b01, 1, 0, 5'd0,  5'd4, 1, 32'h1234,     5'd3, 1, 32'hDEAD,     32'h104,       32'hDEAD};
    vecs[7] = '{4'd12,5'd1, 5'd2, 32'd5,        32'd6,  32'd0, 0, 2'b00, 0, 1, 5'd4,  5'd0, 0, 32'd0,        5'd0, 0, 32'd0,        32'd0,         32'd6};
    vecs[8] = '{4'd0, 5'd7, 5'd8, 32'd1,        32'd2,  32'd0, 0, 2'b11, 0, 1, 5'd11, 5'd8, 1, 32'd300,      5'd7, 1, 32'd55,       32'd355,       32'd300};
    vecs[9] = '{4'd0, 5'd9, 5'd10,32'd4,        32'd6,  32'd0, 0, 2'b11, 0, 1, 5'd12, 5'd9, 0, 32'd1000,     5'd10,1, 32'd40,       32'd44,        32'd40};

    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      in_aluOp = vecs[i].op; in_rs = vecs[i].rs; in_rt = vecs[i].rt;
      in_rsData = vecs[i].rsd; in_rtData = vecs[i].rtd; in_imm = vecs[i].imm;
      in_useImm = vecs[i].useimm; in_memOp = vecs[i].memop; in_memWrite = vecs[i].memwr;
      in_regWrite = vecs[i].regwr; in_rd = vecs[i].rd;
      exmem_rd = vecs[i].exrd; exmem_regWrite = vecs[i].exwe; exmem_result = vecs[i].exres;
      memwb_rd = vecs[i].wbrd; memwb_regWrite = vecs[i].wbwe; memwb_result = vecs[i].wbres;
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      check($sformatf("vec%0d aluResult", i), aluResult, vecs[i].exp_res);
      check($sformatf("vec%0d address", i), address, vecs[i].exp_res);
      check($sformatf("vec%0d dataIn", i), dataIn, vecs[i].exp_din);
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d memOp", i), {30'd0, memOp}, {30'd0, vecs[i].memop});
      check($sformatf("vec%0d writeEnable", i), {31'd0, writeEnable}, {31'd0, vecs[i].memwr});
      check($sformatf("vec%0d out_regWrite", i), {31'd0, out_regWrite}, {31'd0, vecs[i].regwr});
      check($sformatf("vec%0d out_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
    end

    // Random single-cycle traffic including back-to-back accepts and bubbles
    m_res = 0; m_din = 0; m_rd = 0; m_memop = 2'b11; m_valid = 0; m_we = 0; m_rw = 0;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 14);
      in_aluOp = (r >= 9) ? 4'(r + 1) : 4'(r);
      in_rs = 5'($urandom_range(0, 3)); in_rt = 5'($urandom_range(0, 3));
      in_rd = 5'($urandom_range(0, 31));
      in_rsData = $urandom; in_rtData = $urandom; in_imm = $urandom;
      in_useImm = 1'($urandom_range(0, 1));
      in_memOp = 2'($urandom_range(0, 3));
      in_memWrite = 1'($urandom_range(0, 1)); in_regWrite = 1'($urandom_range(0, 1));
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_regWrite = 1'($urandom_range(0, 1)); memwb_regWrite = 1'($urandom_range(0, 1));
      exmem_result = $urandom; memwb_result = $urandom;
      in_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (in_valid) begin
        m_valid = 1;
        m_din = ref_fwd(in_rt, in_rtData);
        m_res = ref_alu(in_aluOp, ref_fwd(in_rs, in_rsData), in_useImm ? in_imm : m_din);
        m_rd = in_rd; m_memop = in_memOp; m_we = in_memWrite; m_rw = in_regWrite;
      end else begin
        m_valid = 0; m_memop = 2'b11; m_we = 0; m_rw = 0;
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d out_valid", i), {31'd0, out_valid}, {31'd0, m_valid});
      check($sformatf("rnd%0d aluResult", i), aluResult, m_res);
      check($sformatf("rnd%0d dataIn", i), dataIn, m_din);
      check($sformatf("rnd%0d out_rd", i), {27'd0, out_rd}, {27'd0, m_rd});
      check($sformatf("rnd%0d memOp", i), {30'd0, memOp}, {30'd0, m_memop});
      check($sformatf("rnd%0d we/rw", i), {30'd0, writeEnable, out_regWrite}, {30'd0, m_we, m_rw});
    end
    clear_inputs();
    @(posedge clk); #1;

    run_mul(32'hFFFFFFFF, 32'd3, 1'b1, "mul_spec");
    for (int i = 0; i < 3; i++)
      run_mul($urandom, $urandom, 1'b0, $sformatf("mul_rnd%0d", i));

    // Flush at multiply cycle 10: bubble, ready next cycle, no result ever
    clear_inputs();
    in_aluOp = 4'd9; in_rsData = 32'd6; in_rtData = 32'd7; in_rd = 5'd9; in_regWrite = 1;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1;
    check("pre-flush busy", {31'd0, in_ready}, 32'd0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    check("flush memOp", {30'd0, memOp}, 32'd3);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("flush no result", pulses, 32'd0);

    // Reset mid-multiply returns every output to its reset value
    in_aluOp = 4'd9; in_rsData = 32'd6; in_rtData = 32'd7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check_reset_vals("midmul_reset");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("reset no result", pulses, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
